muldiv_unit: RTL and testbench

Iterative RV64M multiply/divide unit in the Execute stage, alongside the single-cycle ALU. It accepts one operation at a time from the ID/EX register and holds the pipeline through the hazard unit while the operation is in flight. It returns a full-width result for writeback via the EX/MEM register. XLEN is parametrised, and a flush input abandons the operation in flight, which the single-cycle ALU path never needed.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the ID/EX stage and the iterative
// multiply/divide unit. The pipeline side drives the request and the kill
// input; the unit drives the status signals and the result.
interface muldiv_unit_if #(
  parameter int XLEN = 64
);
  logic            Start_E;
  logic [2:0]      Op_E;
  logic            Word_E;
  logic [XLEN-1:0] SrcA_E;
  logic [XLEN-1:0] SrcB_E;
  logic            Kill_E;
  logic            Busy_E;
  logic            Done_E;
  logic [XLEN-1:0] Result_E;

  modport master (
    output Start_E, Op_E, Word_E, SrcA_E, SrcB_E, Kill_E,
    input  Busy_E, Done_E, Result_E
  );

  modport slave (
    input  Start_E, Op_E, Word_E, SrcA_E, SrcB_E, Kill_E,
    output Busy_E, Done_E, Result_E
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the Execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, operating on
// magnitudes with a sign fix-up pass afterwards. Word variants run 32
// iterations and sign-extend their result from bit 31. Early-out divides
// (divide by zero, signed overflow) skip CALC and carry a preset result
// through FIX untouched.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave mdu
);

  localparam int              CW     = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_X = CW'(XLEN - 1);
  localparam logic [CW-1:0]   LAST_W = CW'(31);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t            state, state_next;

  // Latched request
  logic [2:0]        op;
  logic              word;      // effective word width (only word-capable ops)
  logic [XLEN-1:0]   src_a, src_b;

  // Iteration state
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod, mcand;
  logic [XLEN-1:0]   mplier, dvsr, quo, rem;
  logic              neg_lo;    // negate product / quotient
  logic              neg_rem;   // negate remainder
  logic [XLEN-1:0]   result;

  // Operand preparation (combinational, from the latched request)
  logic              sign_a, sign_b, a_neg, b_neg, a_min, div_zero, div_ovf, early;
  logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b;

  // Iteration and fix-up helpers
  logic [XLEN:0]     shifted, diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, raw, fix_val;
  logic              busy, done;

  // Operand signedness, width extension, magnitudes and early-out detection
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    sign_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sign_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    ext_a  = src_a;
    ext_b  = src_b;
    if (word) begin
      for (int i = 32; i < XLEN; i++) begin
        ext_a[i] = sign_a & src_a[31];
        ext_b[i] = sign_b & src_b[31];
      end
    end
    a_neg    = sign_a & ext_a[XLEN-1];
    b_neg    = sign_b & ext_b[XLEN-1];
    mag_a    = a_neg ? -ext_a : ext_a;
    mag_b    = b_neg ? -ext_b : ext_b;
    a_min    = word ? (ext_a[31:0] == 32'h8000_0000)
                    : (ext_a == {1'b1, {(XLEN-1){1'b0}}});
    div_zero = (ext_b == '0);
    div_ovf  = sign_a & a_min & (ext_b == '1);
    early    = op[2] & (div_zero | div_ovf);
  end

  // One restoring-divide trial subtraction
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvsr};
  end

  // Sign fix-up, result selection and word sign-extension
  always_comb begin
    prod_fix = neg_lo  ? -prod : prod;
    quo_fix  = neg_lo  ? -quo  : quo;
    rem_fix  = neg_rem ? -rem  : rem;
    unique case (op)
      3'b000:                 raw = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: raw = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         raw = quo_fix;
      default:                raw = rem_fix;
    endcase
    fix_val = raw;
    if (word) begin
      for (int i = 32; i < XLEN; i++) fix_val[i] = raw[31];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic and status outputs; kill wins over everything
  always_comb begin
    state_next = state;
    busy       = (state == PREP) || (state == CALC) || (state == FIX);
    done       = (state == DONE);
    unique case (state)
      IDLE: if (mdu.Start_E) state_next = PREP;
      PREP: state_next = early ? FIX : CALC;
      CALC: if (cnt == (word ? LAST_W : LAST_X)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (mdu.Kill_E) state_next = IDLE;
  end

  // Datapath: latch request, prepare operands, iterate, capture result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op      <= '0;
      word    <= 1'b0;
      src_a   <= '0;
      src_b   <= '0;
      cnt     <= '0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      dvsr    <= '0;
      quo     <= '0;
      rem     <= '0;
      neg_lo  <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mdu.Start_E && !mdu.Kill_E) begin
            op    <= mdu.Op_E;
            word  <= mdu.Word_E && (XLEN == 64) && ((mdu.Op_E == 3'b000) || mdu.Op_E[2]);
            src_a <= mdu.SrcA_E;
            src_b <= mdu.SrcB_E;
          end
        end
        PREP: begin
          cnt <= '0;
          if (early) begin
            neg_lo  <= 1'b0;
            neg_rem <= 1'b0;
            quo     <= div_zero ? '1 : ext_a;
            rem     <= div_zero ? ext_a : '0;
          end else begin
            neg_lo  <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (op[2]) begin
              dvsr <= mag_b;
              rem  <= '0;
              // Park a word dividend at the top so the MSB-first loop sees it first.
              quo  <= word ? (mag_a << 32) : mag_a;
            end else begin
              prod   <= '0;
              mcand  <= {{XLEN{1'b0}}, mag_a};
              mplier <= mag_b;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op[2]) begin
            if (!diff[XLEN]) begin
              rem <= diff[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= shifted[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b0};
            end
          end else begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        FIX: begin
          if (!mdu.Kill_E) result <= fix_val;
        end
        default: ;
      endcase
    end
  end

  assign mdu.Busy_E   = busy;
  assign mdu.Done_E   = done;
  assign mdu.Result_E = result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=64).
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_unit_if #(.XLEN(64)) mdu ();

  muldiv_unit #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  // Issue one request and follow it to Done_E. lat counts edges after t0
  // until Done_E is seen (-1 on timeout); busy_cyc counts sampled cycles
  // with Busy_E high; done_again is Done_E in the cycle after the pulse.
  task automatic run_op(input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat,
                        output int busy_cyc, output logic done_again);
    @(negedge clk);
    mdu.Start_E = 1'b1;
    mdu.Op_E    = op;
    mdu.Word_E  = word;
    mdu.SrcA_E  = a;
    mdu.SrcB_E  = b;
    @(posedge clk); #1;
    mdu.Start_E = 1'b0;
    lat        = -1;
    res        = 'x;
    done_again = 1'bx;
    busy_cyc   = mdu.Busy_E ? 1 : 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (lat >= 0) begin
        done_again = mdu.Done_E;
        break;
      end
      if (mdu.Busy_E) busy_cyc++;
      if (mdu.Done_E) begin
        lat = k;
        res = mdu.Result_E;
      end
    end
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    mdu.Start_E = 1'b0;
    mdu.Kill_E  = 1'b0;
    mdu.Op_E    = '0;
    mdu.Word_E  = 1'b0;
    mdu.SrcA_E  = '0;
    mdu.SrcB_E  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mdu.Busy_E !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mdu.Busy_E); end
    checks++; if (mdu.Done_E !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", mdu.Done_E); end
    checks++; if (mdu.Result_E !== 64'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", mdu.Result_E); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mul();
    logic [63:0] r; int lat; int bc; logic da;
    run_op(MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, r, lat, bc, da);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffffffffffeb", r); end
    checks++; if (lat !== 66) begin failures++; $display("FAIL mul_latency got=%0d exp=66", lat); end
    checks++; if (bc !== 66) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=66", bc); end
    checks++; if (da !== 1'b0) begin failures++; $display("FAIL mul_done_single got=%b exp=0", da); end
  endtask

  task automatic test_mul_high();
    logic [63:0] r; int lat; int bc; logic da;
    run_op(MULH, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, r, lat, bc, da);
    checks++; if (r !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL mulh_result got=%h exp=4000000000000000", r); end
    run_op(MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bc, da);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulhu_result got=%h exp=fffffffffffffffe", r); end
    // -1 (signed) x 2 (unsigned) = -2, high half all ones
    run_op(MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, lat, bc, da);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL mulhsu_result got=%h exp=ffffffffffffffff", r); end
    // MULW: 0x7fffffff * 2 = 0xfffffffe, sign-extended
    run_op(MUL, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, r, lat, bc, da);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulw_result got=%h exp=fffffffffffffffe", r); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL mulw_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_div();
    logic [63:0] r; int lat; int bc; logic da;
    run_op(DIV, 1'b0, -64'sd20, 64'd3, r, lat, bc, da);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFA) begin failures++; $display("FAIL div_result got=%h exp=fffffffffffffffa", r); end
    checks++; if (lat !== 66) begin failures++; $display("FAIL div_latency got=%0d exp=66", lat); end
    run_op(REM, 1'b0, -64'sd20, 64'd3, r, lat, bc, da);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL rem_result got=%h exp=fffffffffffffffe", r); end
    checks++; if (lat !== 66) begin failures++; $display("FAIL rem_latency got=%0d exp=66", lat); end
    run_op(REMU, 1'b0, 64'd20, 64'd3, r, lat, bc, da);
    checks++; if (r !== 64'd2) begin failures++; $display("FAIL remu_result got=%h exp=2", r); end
    checks++; if (lat !== 66) begin failures++; $display("FAIL remu_latency got=%0d exp=66", lat); end
  endtask

  task automatic test_early_out();
    logic [63:0] r; int lat; int bc; logic da;
    run_op(DIVU, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, r, lat, bc, da);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divu_zero_result got=%h exp=ffffffffffffffff", r); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL divu_zero_latency got=%0d exp=2", lat); end
    run_op(REM, 1'b0, 64'd5, 64'd0, r, lat, bc, da);
    checks++; if (r !== 64'd5) begin failures++; $display("FAIL rem_zero_result got=%h exp=5", r); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL rem_zero_latency got=%0d exp=2", lat); end
    run_op(DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bc, da);
    checks++; if (r !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL div_ovf_result got=%h exp=8000000000000000", r); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL div_ovf_latency got=%0d exp=2", lat); end
    run_op(REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, bc, da);
    checks++; if (r !== 64'h0) begin failures++; $display("FAIL rem_ovf_result got=%h exp=0", r); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL rem_ovf_busy_cycles got=%0d exp=2", bc); end
  endtask

  task automatic test_word();
    logic [63:0] r; int lat; int bc; logic da;
    run_op(DIV, 1'b1, 64'h0000_0001_8000_0000, 64'd1, r, lat, bc, da);
    checks++; if (r !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL divw_result got=%h exp=ffffffff80000000", r); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL divw_latency got=%0d exp=34", lat); end
    // REMW: -7 rem 2 = -1
    run_op(REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, r, lat, bc, da);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL remw_result got=%h exp=ffffffffffffffff", r); end
  endtask

  task automatic test_kill();
    logic [63:0] r; int lat; int bc; logic da; int dones;
    run_op(DIVU, 1'b0, 64'd100, 64'd7, r, lat, bc, da);
    checks++; if (r !== 64'd14) begin failures++; $display("FAIL kill_setup_result got=%h exp=e", r); end
    // Second operation, killed while in CALC (state CALC from edge t0+1)
    @(negedge clk);
    mdu.Start_E = 1'b1; mdu.Op_E = MUL; mdu.Word_E = 1'b0; mdu.SrcA_E = 64'd9; mdu.SrcB_E = 64'd9;
    @(posedge clk); #1;
    mdu.Start_E = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    mdu.Kill_E = 1'b1;
    @(posedge clk); #1;
    mdu.Kill_E = 1'b0;
    checks++; if (mdu.Busy_E !== 1'b0) begin failures++; $display("FAIL kill_busy got=%b exp=0", mdu.Busy_E); end
    checks++; if (mdu.Done_E !== 1'b0) begin failures++; $display("FAIL kill_done got=%b exp=0", mdu.Done_E); end
    dones = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (mdu.Done_E) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL kill_no_done got=%0d exp=0", dones); end
    checks++; if (mdu.Result_E !== 64'd14) begin failures++; $display("FAIL kill_result_held got=%h exp=e", mdu.Result_E); end
  endtask

  task automatic test_start_with_kill();
    int dones; int busies;
    @(negedge clk);
    mdu.Start_E = 1'b1; mdu.Kill_E = 1'b1; mdu.Op_E = MUL; mdu.SrcA_E = 64'd3; mdu.SrcB_E = 64'd3;
    @(posedge clk); #1;
    mdu.Start_E = 1'b0; mdu.Kill_E = 1'b0;
    checks++; if (mdu.Busy_E !== 1'b0) begin failures++; $display("FAIL startkill_busy got=%b exp=0", mdu.Busy_E); end
    dones = 0; busies = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (mdu.Done_E) dones++;
      if (mdu.Busy_E) busies++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL startkill_no_done got=%0d exp=0", dones); end
    checks++; if (busies !== 0) begin failures++; $display("FAIL startkill_no_busy got=%0d exp=0", busies); end
    checks++; if (mdu.Result_E !== 64'd14) begin failures++; $display("FAIL startkill_result_held got=%h exp=e", mdu.Result_E); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; int lat; int bc; logic da;
    @(negedge clk);
    mdu.Start_E = 1'b1; mdu.Op_E = MUL; mdu.Word_E = 1'b0; mdu.SrcA_E = 64'd5; mdu.SrcB_E = 64'd6;
    @(posedge clk); #1;
    mdu.Start_E = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mdu.Busy_E !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", mdu.Busy_E); end
    checks++; if (mdu.Done_E !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", mdu.Done_E); end
    checks++; if (mdu.Result_E !== 64'h0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", mdu.Result_E); end
    @(negedge clk);
    rst = 1'b1;
    run_op(MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, r, lat, bc, da);
    checks++; if (r !== 64'hF) begin failures++; $display("FAIL rstmid_recover_result got=%h exp=f", r); end
    checks++; if (lat !== 66) begin failures++; $display("FAIL rstmid_recover_latency got=%0d exp=66", lat); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r; int lat; int bc; logic da;
    run_op(DIVU, 1'b0, 64'd20, 64'd3, r, lat, bc, da);
    checks++; if (r !== 64'd6) begin failures++; $display("FAIL b2b_first got=%h exp=6", r); end
    run_op(MUL, 1'b0, 64'd6, 64'd7, r, lat, bc, da);
    checks++; if (r !== 64'd42) begin failures++; $display("FAIL b2b_second got=%h exp=2a", r); end
    checks++; if (lat !== 66) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=66", lat); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_early_out();
    test_word();
    test_kill();
    test_start_with_kill();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
